gxor_gate: RTL and testbench
============================

Name: gxor_gate

Overview:
- Bitwise XOR gate with a purely combinational output `y = a ^ b` (zero latency).
- Also provides a registered copy of the XOR result, with valid qualification, a Hamming-distance count and a parity bit.
- Used as a leaf primitive wherever signals are compared or parity is needed.
- With WIDTH=1 it behaves as a plain 2-input XOR gate.

Parameters:
- WIDTH, 1, bit width of operands a, b and result y (legal range 1..64).
- DW, $clog2(WIDTH+1) (derived, minimum 1), width of the Hamming-distance output.

Ports:
- clk  input  1  rising-edge clock for all registered outputs
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_valid  input  1  qualifies a/b for capture into the registered outputs
- y  output  WIDTH  combinational a XOR b
- y_q  output  WIDTH  registered a XOR b
- dist_q  output  DW  registered popcount(a XOR b), the Hamming distance
- parity_q  output  1  registered reduction-XOR of (a XOR b)
- out_valid  output  1  registered copy of in_valid

Behaviour:
- y is purely combinational: y = a ^ b, bit for bit, with zero latency. It ignores clk, rst and in_valid.
  - WIDTH=1 truth table: 00->0, 01->1, 10->1, 11->0.
- y updates in the same simulation timestep as any change on a or b. It never glitches to X when the inputs are known.
- Registered path, evaluated on each rising clk edge:
  - rst=1: y_q=0, dist_q=0, parity_q=0, out_valid=0. Reset has priority over in_valid.
  - rst=0, in_valid=1: y_q<=a^b; dist_q<=number of 1 bits in a^b; parity_q<=^(a^b); out_valid<=1.
  - rst=0, in_valid=0: y_q, dist_q and parity_q hold their values; out_valid<=0.
- Latency of the registered path: exactly 1 cycle from the edge sampling in_valid=1.
- Throughput: one result per cycle. There is no backpressure; back-to-back in_valid is legal.
- dist_q range is 0..WIDTH. It never wraps, because DW is sized for WIDTH+1 values.
- parity_q always equals dist_q[0].
- Reset asserted mid-stream clears the registered outputs on the next edge. The combinational y is unaffected by reset.
- X or Z on a/b propagates to y per standard Verilog XOR semantics. No special handling.

Decomposition:
- Shared package holds no typedefs. Only the helper function for the DW computation belongs there.
- One natural sub-module: gxor_popcount, a combinational adder tree counting the ones in a WIDTH vector.
- The XOR array and the output registers stay in gxor_gate.

Test Plan:
- WIDTH=1, combinational sweep with 10-time-unit steps: (a,b)=(0,0)->y=0; (0,1)->y=1; (1,0)->y=1; (1,1)->y=0. Check y immediately after each change, independent of clk.
- Reset: hold rst=1 for 2 cycles with in_valid=1 and a=1, b=0 -> y_q=0, dist_q=0, parity_q=0, out_valid=0, while y=1 combinationally.
- WIDTH=8, in_valid=1 with a=8'hF0, b=8'h0F -> next cycle y_q=8'hFF, dist_q=8, parity_q=0, out_valid=1.
- WIDTH=8, back-to-back vectors (8'hAA,8'hAA) then (8'h01,8'h00) -> dist_q sequence 0 then 1, parity_q 0 then 1, out_valid high both cycles.
- Hold behaviour: a valid result, then in_valid=0 with new a/b -> y_q and dist_q unchanged, out_valid=0, combinational y tracks the new inputs.
- Reset mid-stream: assert rst during continuous in_valid -> registered outputs cleared the next cycle; normal results resume one cycle after rst drops.

Source files
------------

// File: rtl/gxor_gate_pkg.sv
// gxor_gate_pkg: sizing helper shared by the XOR gate and its popcount
package gxor_gate_pkg;

    function automatic int dist_width(input int width);
        return (width < 1) ? 1 : (($clog2(width + 1) < 1) ? 1 : $clog2(width + 1));
    endfunction

endpackage

// File: rtl/gxor_popcount.sv
// gxor_popcount: combinational count of the ones in a WIDTH-bit vector
module gxor_popcount
    import gxor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    localparam int DW = dist_width(WIDTH)
) (
    input  logic [WIDTH-1:0] v,
    output logic [DW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + DW'(v[i]);
    end

endmodule

// File: rtl/gxor_gate.sv
// gxor_gate: bitwise XOR with registered result, Hamming distance and parity
module gxor_gate
    import gxor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    localparam int DW = dist_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [DW-1:0]    dist_q,
    output logic             parity_q,
    output logic             out_valid
);

    logic [DW-1:0] cnt;

    assign y = a ^ b;

    gxor_popcount #(.WIDTH(WIDTH)) u_popcount (.v(y), .cnt(cnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            dist_q    <= '0;
            parity_q  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q      <= y;
                dist_q   <= cnt;
                parity_q <= ^y;
            end
        end
    end

endmodule

// File: tb/tb_gxor_gate.sv
// tb_gxor_gate: directed and randomized checks of gxor_gate at WIDTH 1 and 8
module tb_gxor_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a1 = 1'b0, b1 = 1'b0, iv1 = 1'b0;
    logic y1, yq1, dq1, pq1, ov1;
    logic [7:0] a8 = '0, b8 = '0, y8, yq8;
    logic iv8 = 1'b0;
    logic [3:0] dq8;
    logic pq8, ov8;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] m_y = '0;
    logic [3:0] m_d = '0;
    logic m_p = 1'b0, m_v = 1'b0;

    always #5 clk = ~clk;

    gxor_gate #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
        .y(y1), .y_q(yq1), .dist_q(dq1), .parity_q(pq1), .out_valid(ov1)
    );

    gxor_gate #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8),
        .y(y8), .y_q(yq8), .dist_q(dq8), .parity_q(pq8), .out_valid(ov8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: Hamming distance as a plain count, parity as its oddness
    task automatic cycle();
        int ones;
        @(posedge clk);
        ones = 0;
        for (int i = 0; i < 8; i++) if (a8[i] != b8[i]) ones++;
        if (rst) begin
            m_y = '0; m_d = '0; m_p = 1'b0; m_v = 1'b0;
        end else begin
            m_v = iv8;
            if (iv8) begin
                m_y = a8 ^ b8;
                m_d = 4'(ones);
                m_p = (ones % 2) == 1;
            end
        end
        @(negedge clk);
        check("w8_y", y8, a8 ^ b8);
        check("w8_y_q", yq8, m_y);
        check("w8_dist_q", dq8, m_d);
        check("w8_parity_q", pq8, m_p);
        check("w8_out_valid", ov8, m_v);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] x, input logic [7:0] z);
        rst = r; iv8 = v; a8 = x; b8 = z;
    endtask

    initial begin
        a1 = 0; b1 = 0; #1 check("w1_00", y1, 1'b0);
        #9 b1 = 1;      #1 check("w1_01", y1, 1'b1);
        #9 a1 = 1; b1 = 0; #1 check("w1_10", y1, 1'b1);
        #9 b1 = 1;      #1 check("w1_11", y1, 1'b0);
        @(negedge clk);
        rst = 1; iv1 = 1; a1 = 1; b1 = 0;
        drive(1, 1, 8'h5A, 8'h0F);
        cycle();
        cycle();
        check("w1_rst_y", y1, 1'b1);
        check("w1_rst_y_q", yq1, 1'b0);
        check("w1_rst_dist_q", dq1, 1'b0);
        check("w1_rst_parity_q", pq1, 1'b0);
        check("w1_rst_out_valid", ov1, 1'b0);
        drive(0, 1, 8'hF0, 8'h0F);
        cycle();
        check("w1_y_q", yq1, 1'b1);
        check("w1_dist_q", dq1, 1'b1);
        check("w1_parity_q", pq1, 1'b1);
        check("w1_out_valid", ov1, 1'b1);
        check("w8_ff_y_q", yq8, 8'hFF);
        check("w8_ff_dist_q", dq8, 4'd8);
        check("w8_ff_parity_q", pq8, 1'b0);
        iv1 = 0;
        drive(0, 1, 8'hAA, 8'hAA);
        cycle();
        check("w8_b2b0_dist_q", dq8, 4'd0);
        drive(0, 1, 8'h01, 8'h00);
        cycle();
        check("w8_b2b1_dist_q", dq8, 4'd1);
        check("w8_b2b1_parity_q", pq8, 1'b1);
        check("w8_b2b1_out_valid", ov8, 1'b1);
        drive(0, 0, 8'h33, 8'hC3);
        cycle();
        check("w8_hold_y_q", yq8, 8'h01);
        check("w8_hold_out_valid", ov8, 1'b0);
        check("w8_hold_y", y8, 8'hF0);
        drive(0, 1, 8'h7E, 8'h00);
        cycle();
        drive(1, 1, 8'hFF, 8'h00);
        cycle();
        check("w8_midrst_y_q", yq8, 8'h00);
        drive(0, 1, 8'h0F, 8'h00);
        cycle();
        check("w8_resume_dist_q", dq8, 4'd4);
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 19) == 0, 1'($urandom), 8'($urandom), 8'($urandom));
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
